// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide (shift-add / restoring divide) beside the ALU.
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and zero-operand multiply in one cycle.
module muldiv_sequencer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0] f3;
    logic an, bn, bz;
    logic [N-1:0] m;
    logic [2*N-1:0] acc;
    logic sa, sb, a_neg, b_neg, accept, early;
    logic [N-1:0] a_mag, b_mag, q, r, qf, rf, fix_res, early_res;
    logic [N:0] sum, diff;
    logic [2*N-1:0] prod, acc_mul, acc_div;

    assign sa     = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign sb     = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign a_neg  = sa & op_a[N-1];
    assign b_neg  = sb & op_b[N-1];
    assign a_mag  = a_neg ? -op_a : op_a;
    assign b_mag  = b_neg ? -op_b : op_b;
    assign accept = (state == IDLE) && start && !flush;
    assign busy   = state != IDLE;
    assign done   = state == DONE;

    // multiply keeps the multiplier in acc's low half; divide keeps {remainder, dividend/quotient}
    assign sum     = {1'b0, acc[2*N-1:N]} + {1'b0, m};
    assign diff    = {acc[2*N-1:N], acc[N-1]} - {1'b0, m};
    assign acc_mul = acc[0] ? {sum, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};
    assign acc_div = diff[N] ? {acc[2*N-2:0], 1'b0} : {diff[N-1:0], acc[N-2:0], 1'b1};

    assign prod    = (an ^ bn) ? -acc : acc;
    assign q       = acc[N-1:0];
    assign r       = acc[2*N-1:N];
    assign qf      = bz ? '1 : ((an ^ bn) ? -q : q);
    assign rf      = an ? -r : r;
    assign fix_res = f3[2] ? (f3[1] ? rf : qf) : (f3[1:0] == 2'b00 ? prod[N-1:0] : prod[2*N-1:N]);

`ifdef MULDIV_EARLY_OUT_EN
    logic ovf, bz_in;
    assign bz_in     = op_b == '0;
    assign ovf       = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(N-1){1'b0}}}) & (&op_b);
    assign early     = funct3[2] ? (bz_in | ovf) : (op_a == '0 || op_b == '0);
    assign early_res = !funct3[2] ? '0 :
                       funct3[1] ? (bz_in ? op_a : '0) : (bz_in ? '1 : {1'b1, {(N-1){1'b0}}});
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: state_n = accept ? (early ? DONE : CALC) : IDLE;
            CALC: state_n = flush ? IDLE : (cnt == '0 ? FIX : CALC);
            FIX:  state_n = flush ? IDLE : DONE;
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            f3     <= '0;
            an     <= 1'b0;
            bn     <= 1'b0;
            bz     <= 1'b0;
            m      <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                f3  <= funct3;
                an  <= a_neg;
                bn  <= b_neg;
                bz  <= op_b == '0;
                cnt <= CW'(N - 1);
                m   <= funct3[2] ? b_mag : a_mag;
                acc <= {{N{1'b0}}, funct3[2] ? a_mag : b_mag};
            end else if (state == CALC) begin
                acc <= f3[2] ? acc_div : acc_mul;
                cnt <= cnt - CW'(1);
            end
            if (state_n == DONE)
                result <= (state == IDLE) ? early_res : fix_res;
        end
    end
endmodule
